// File: rtl/cache_2way_wb_ctrl.sv
// 2-way set-associative write-back/write-allocate cache controller, one word per line.
// Single-bit LRU per set, req/ack memory port, saturating hit/miss statistics.
module cache_2way_wb_ctrl #(
  parameter int DATA_W  = 8,
  parameter int TAG_W   = 3,
  parameter int INDEX_W = 2,
  parameter int COUNT_W = 16,
  localparam int ADDR_W = TAG_W + INDEX_W,
  localparam int SETS   = 2**INDEX_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cpu_req,
  input  logic               cpu_wren,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_ready,
  output logic               cpu_done,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               hit,
  output logic               write_back,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

  typedef struct packed {
    logic              vld;
    logic              dty;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  state_t state, state_n;
  line_t [1:0][SETS-1:0] line_q;
  logic  [SETS-1:0]      lru_q;

  logic                wren_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                miss_q;
  logic                vict_q;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tg;
  logic [1:0]          way_hit;
  logic                any_hit, hway, vict;
  line_t               vline;

  assign idx = addr_q[INDEX_W-1:0];
  assign tg  = addr_q[ADDR_W-1:INDEX_W];

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign way_hit[w] = line_q[w][idx].vld && (line_q[w][idx].tag == tg);
  end

  assign any_hit = |way_hit;
  assign hway    = way_hit[1];
  // Empty ways are filled before anything valid is evicted.
  assign vict    = !line_q[0][idx].vld ? 1'b0 :
                   !line_q[1][idx].vld ? 1'b1 : lru_q[idx];
  assign vline   = line_q[vict][idx];

  // Memory handshake decoded from state so reset drops mem_req immediately.
  assign cpu_ready  = (state == IDLE);
  assign mem_req    = (state == WRITEBACK) || (state == FILL);
  assign mem_we     = (state == WRITEBACK);
  assign write_back = (state == WRITEBACK);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (cpu_req) state_n = COMPARE;
      COMPARE:   if (any_hit)                     state_n = IDLE;
                 else if (vline.vld && vline.dty) state_n = WRITEBACK;
                 else                             state_n = FILL;
      WRITEBACK: if (mem_ack) state_n = FILL;
      FILL:      if (mem_ack) state_n = COMPARE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_q     <= '0;
      lru_q      <= '0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      miss_q     <= 1'b0;
      vict_q     <= 1'b0;
      cpu_done   <= 1'b0;
      hit        <= 1'b0;
      cpu_rdata  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_done <= 1'b0;
      hit      <= 1'b0;
      case (state)
        IDLE: if (cpu_req) begin
          wren_q  <= cpu_wren;
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
          miss_q  <= 1'b0;
        end
        COMPARE: if (any_hit) begin
          if (wren_q) begin
            line_q[hway][idx].data <= wdata_q;
            line_q[hway][idx].dty  <= 1'b1;
          end else begin
            cpu_rdata <= line_q[hway][idx].data;
          end
          lru_q[idx] <= ~hway;
          cpu_done   <= 1'b1;
          hit        <= ~miss_q;
          // A post-fill re-lookup hit is still accounted as a miss.
          if (!miss_q) begin
            if (hit_count != {COUNT_W{1'b1}}) hit_count <= hit_count + COUNT_W'(1);
          end else begin
            if (miss_count != {COUNT_W{1'b1}}) miss_count <= miss_count + COUNT_W'(1);
          end
        end else begin
          miss_q <= 1'b1;
          vict_q <= vict;
          if (vline.vld && vline.dty) begin
            mem_addr  <= {vline.tag, idx};
            mem_wdata <= vline.data;
          end else begin
            mem_addr  <= addr_q;
          end
        end
        WRITEBACK: if (mem_ack) begin
          line_q[vict_q][idx].dty <= 1'b0;
          mem_addr                <= addr_q;
        end
        FILL: if (mem_ack) begin
          line_q[vict_q][idx] <= '{vld: 1'b1, dty: 1'b0, tag: tg, data: mem_rdata};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_2way_wb_ctrl.sv
// Bench for cache_2way_wb_ctrl: directed table, stall/reset sequences, random traffic
// against a transparent-memory reference model with its own tag/LRU bookkeeping.
module tb_cache_2way_wb_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_req = 1'b0, cpu_wren = 1'b0;
  logic [4:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_ready, cpu_done, hit, write_back, mem_req, mem_we;
  logic [7:0] cpu_rdata, mem_wdata;
  logic [4:0] mem_addr;
  logic [7:0] mem_rdata = '0;
  logic       mem_ack = 1'b0;
  logic [15:0] hit_count, miss_count;

  logic       c2_ready, c2_done, c2_hit, c2_wb, c2_mreq, c2_mwe;
  logic [7:0] c2_rdata, c2_mwdata;
  logic [4:0] c2_maddr;
  logic [1:0] c2_hc, c2_mc;

  cache_2way_wb_ctrl dut (
    .clock(clock), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_wren(cpu_wren),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata), .hit(hit), .write_back(write_back), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count));

  // Same traffic, 2-bit counters to exercise saturation.
  cache_2way_wb_ctrl #(.COUNT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_wren(cpu_wren),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(c2_ready), .cpu_done(c2_done),
    .cpu_rdata(c2_rdata), .hit(c2_hit), .write_back(c2_wb), .mem_req(c2_mreq),
    .mem_we(c2_mwe), .mem_addr(c2_maddr), .mem_wdata(c2_mwdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_count(c2_hc), .miss_count(c2_mc));

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;

  logic [7:0] mem  [32];   // backing store the bench serves to the DUT
  logic [7:0] gold [32];   // value a CPU read must return
  bit         mv [2][4], md [2][4];
  logic [2:0] mt [2][4];
  bit         mlru [4];
  int         mh = 0, mm = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 4; s++) begin mv[w][s] = 0; md[w][s] = 0; mt[w][s] = '0; end
    for (int s = 0; s < 4; s++) mlru[s] = 0;
    for (int i = 0; i < 32; i++) gold[i] = mem[i];
    mh = 0; mm = 0;
  endfunction

  // Whole access at once: hit/miss, victim choice, and what a dirty eviction must write.
  function automatic void model_access(input bit we, input logic [4:0] a, input logic [7:0] wd,
      output bit eh, output bit ewb, output logic [4:0] ewa, output logic [7:0] ewd);
    logic [1:0] ix = a[1:0];
    logic [2:0] t  = a[4:2];
    int hw = -1, v;
    ewb = 0; ewa = '0; ewd = '0;
    for (int w = 0; w < 2; w++) if (mv[w][ix] && mt[w][ix] == t) hw = w;
    if (hw >= 0) begin
      eh = 1; mh++;
      if (we) md[hw][ix] = 1;
      mlru[ix] = (hw == 0);
    end else begin
      eh = 0; mm++;
      v = !mv[0][ix] ? 0 : !mv[1][ix] ? 1 : int'(mlru[ix]);
      if (mv[v][ix] && md[v][ix]) begin
        ewb = 1; ewa = {mt[v][ix], ix}; ewd = gold[{mt[v][ix], ix}];
      end
      mv[v][ix] = 1; mt[v][ix] = t; md[v][ix] = we;
      mlru[ix] = (v == 0);
    end
    if (we) gold[a] = wd;
  endfunction

  // Drives one CPU access and plays memory; all sampling at negedges.
  task automatic access(input bit we, input logic [4:0] a, input logic [7:0] wd, input int dly,
      input bit poke, output logic [7:0] rd, output logic h, output int lat, output int nwb,
      output logic [4:0] wba, output logic [7:0] wbd, output bit proto_ok);
    int wcnt = 0;
    bit done = 0;
    logic [4:0] sa = '0;
    logic sw = 1'b0;
    rd = '0; h = 0; lat = 0; nwb = 0; wba = '0; wbd = '0; proto_ok = 1;
    @(negedge clock);
    if (!cpu_ready) proto_ok = 0;
    cpu_req = 1; cpu_wren = we; cpu_addr = a; cpu_wdata = wd;
    @(negedge clock);
    cpu_req = 0; cpu_wren = 1'($urandom); cpu_addr = 5'($urandom); cpu_wdata = 8'($urandom);
    lat = 1;
    while (!done && lat < 200) begin
      mem_ack = 0;
      if (cpu_done) begin
        rd = cpu_rdata; h = hit; done = 1;
      end else begin
        if (cpu_ready) proto_ok = 0;
        if (mem_req) begin
          if (wcnt == 0) begin sa = mem_addr; sw = mem_we; end
          else if (mem_addr !== sa || mem_we !== sw) proto_ok = 0;
          if (write_back !== mem_we) proto_ok = 0;
          if (poke) begin cpu_req = 1; cpu_addr = ~a; end
          if (wcnt == dly) begin
            mem_ack = 1; cpu_req = 0;
            if (mem_we) begin
              mem[mem_addr] = mem_wdata; nwb++; wba = mem_addr; wbd = mem_wdata;
            end else mem_rdata = mem[mem_addr];
            wcnt = 0;
          end else wcnt++;
        end else begin
          if (write_back) proto_ok = 0;
          mem_ack = 1'($urandom);   // stray ack without a request
        end
        @(negedge clock);
        lat++;
      end
    end
    mem_ack = 0;
    chk("done_seen", done, 1);
  endtask

  task automatic run_chk(input bit we, input logic [4:0] a, input logic [7:0] wd, input int dly,
      input bit poke);
    bit eh, ewb, pok;
    logic [4:0] ewa, wba;
    logic [7:0] ewd, erd, rd, wbd;
    logic h;
    int lat, nwb;
    erd = gold[a];
    model_access(we, a, wd, eh, ewb, ewa, ewd);
    access(we, a, wd, dly, poke, rd, h, lat, nwb, wba, wbd, pok);
    chk("hit", h, eh);
    if (!we) chk("rdata", rd, erd);
    chk("latency", lat, eh ? 2 : 2 + (int'(ewb) + 1) * (dly + 1) + 1);
    chk("writebacks", nwb, ewb);
    if (ewb) begin chk("wb_addr", wba, ewa); chk("wb_data", wbd, ewd); end
    chk("protocol", pok, 1);
    chk("hit_count", hit_count, mh > 65535 ? 65535 : mh);
    chk("miss_count", miss_count, mm > 65535 ? 65535 : mm);
    chk("hit_count_sat2", c2_hc, mh > 3 ? 3 : mh);
    chk("miss_count_sat2", c2_mc, mm > 3 ? 3 : mm);
  endtask

  typedef struct {
    bit we; logic [4:0] a; logic [7:0] wd; int dly; bit poke;
    bit eh; logic [7:0] erd; int elat; int ewb; logic [4:0] ewa; logic [7:0] ewd;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit eh, ewb, pok;
    logic [4:0] ewa, wba;
    logic [7:0] ewd, rd, wbd;
    logic h;
    int lat, nwb;

    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    mem[5'h0A] = 8'h5C; mem[5'h1A] = 8'h33; mem[5'h12] = 8'h77;
    mem[5'h07] = 8'hE1; mem[5'h0F] = 8'h21; mem[5'h17] = 8'h44;
    model_reset();

    //          we a      wd     dly poke eh erd    lat wb wa     wd
    tbl[0]  = '{0, 5'h0A, 8'h00, 0, 0,   0, 8'h5C, 4, 0, 5'h00, 8'h00};
    tbl[1]  = '{0, 5'h0A, 8'h00, 0, 0,   1, 8'h5C, 2, 0, 5'h00, 8'h00};
    tbl[2]  = '{1, 5'h0A, 8'hA5, 0, 0,   1, 8'h00, 2, 0, 5'h00, 8'h00};
    tbl[3]  = '{0, 5'h0A, 8'h00, 0, 0,   1, 8'hA5, 2, 0, 5'h00, 8'h00};
    tbl[4]  = '{0, 5'h1A, 8'h00, 1, 0,   0, 8'h33, 5, 0, 5'h00, 8'h00};
    tbl[5]  = '{0, 5'h12, 8'h00, 0, 0,   0, 8'h77, 5, 1, 5'h0A, 8'hA5};
    tbl[6]  = '{0, 5'h0A, 8'h00, 0, 0,   0, 8'hA5, 4, 0, 5'h00, 8'h00};
    tbl[7]  = '{1, 5'h07, 8'h3C, 5, 1,   0, 8'h00, 9, 0, 5'h00, 8'h00};
    tbl[8]  = '{0, 5'h07, 8'h00, 0, 0,   1, 8'h3C, 2, 0, 5'h00, 8'h00};
    tbl[9]  = '{0, 5'h0F, 8'h00, 0, 0,   0, 8'h21, 4, 0, 5'h00, 8'h00};
    tbl[10] = '{0, 5'h17, 8'h00, 0, 0,   0, 8'h44, 5, 1, 5'h07, 8'h3C};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_ready", cpu_ready, 1);
    chk("rst_done", cpu_done, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_wb", write_back, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_counts", {hit_count, miss_count}, 0);
    reset_n = 1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      model_access(tbl[i].we, tbl[i].a, tbl[i].wd, eh, ewb, ewa, ewd);
      access(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].dly, tbl[i].poke, rd, h, lat, nwb, wba, wbd, pok);
      chk($sformatf("t%0d_hit", i), h, tbl[i].eh);
      if (!tbl[i].we) chk($sformatf("t%0d_rdata", i), rd, tbl[i].erd);
      chk($sformatf("t%0d_lat", i), lat, tbl[i].elat);
      chk($sformatf("t%0d_nwb", i), nwb, tbl[i].ewb);
      if (tbl[i].ewb != 0) begin
        chk($sformatf("t%0d_wba", i), wba, tbl[i].ewa);
        chk($sformatf("t%0d_wbd", i), wbd, tbl[i].ewd);
      end
      chk($sformatf("t%0d_proto", i), pok, 1);
    end
    chk("tbl_hit_count", hit_count, 4);
    chk("tbl_miss_count", miss_count, 7);
    chk("tbl_hit_sat2", c2_hc, 3);
    chk("tbl_miss_sat2", c2_mc, 3);

    // Reset while a fill is outstanding
    @(negedge clock);
    cpu_req = 1; cpu_wren = 0; cpu_addr = 5'h1F;
    @(negedge clock);
    cpu_req = 0;
    @(negedge clock);
    chk("fill_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 5'h1F});
    #2 reset_n = 0;
    #1;
    chk("abort_memreq", mem_req, 0);
    chk("abort_ready", cpu_ready, 1);
    chk("abort_counts", {hit_count, miss_count}, 0);
    @(negedge clock);
    reset_n = 1;
    model_reset();
    run_chk(0, 5'h1F, 8'h00, 0, 0);
    run_chk(0, 5'h0A, 8'h00, 1, 0);

    // Random traffic
    for (int n = 0; n < 300; n++)
      run_chk(1'($urandom), 5'($urandom_range(0, 15)), 8'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
